// File: rtl/great_deserializer.sv
// Reassembles a number streamed LSB-chunk-first into one BITS_IN_NUM-bit word,
// presents it on a ready/valid handshake and flags framing errors.
module great_deserializer #(
   parameter int REGISTER_SIZE = 32,
   parameter int BITS_IN_NUM   = 2048
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic [REGISTER_SIZE-1:0] data_in,
   input  logic                     valid_in,
   input  logic                     final_in,
   output logic [BITS_IN_NUM-1:0]   data_out,
   output logic                     valid_out,
   input  logic                     ready_in,
   output logic                     zero_out,
   output logic                     error_out,
   output logic [1:0]               error_code,
   output logic                     busy_out
);

   localparam int CHUNKS = BITS_IN_NUM / REGISTER_SIZE;
   localparam int CW     = (CHUNKS > 2) ? $clog2(CHUNKS) : 1;
   localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      COLLECT = 2'b01,
      HOLD    = 2'b10,
      DROP    = 2'b11
   } state_t;

   state_t          state_r, state_s;
   logic [CW-1:0]   cnt_r, cnt_s;
   logic            or_r, or_s;
   logic            store_s;
   logic            err_s;
   logic [1:0]      code_s;
   logic            valid_s;
   logic            zero_s;

   // Next-state, chunk acceptance and error decisions
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      or_s    = or_r;
      store_s = 1'b0;
      err_s   = 1'b0;
      code_s  = error_code;
      valid_s = valid_out;
      zero_s  = zero_out;
      case (state_r)
         IDLE, COLLECT: begin
            if (valid_in) begin
               if (cnt_r != LAST) begin
                  if (!final_in) begin
                     store_s = 1'b1;
                     cnt_s   = cnt_r + CW'(1);
                     state_s = COLLECT;
                     or_s    = ((cnt_r == '0) ? 1'b0 : or_r) | (|data_in);
                  end else begin
                     err_s   = 1'b1;
                     code_s  = 2'b01;
                     cnt_s   = '0;
                     state_s = IDLE;
                  end
               end else begin
                  cnt_s = '0;
                  if (final_in) begin
                     store_s = 1'b1;
                     state_s = HOLD;
                     valid_s = 1'b1;
                     zero_s  = ~(or_r | (|data_in));
                  end else begin
                     err_s   = 1'b1;
                     code_s  = 2'b10;
                     state_s = IDLE;
                  end
               end
            end else begin
               state_s = state_r;
            end
         end
         HOLD: begin
            if (ready_in) begin
               valid_s = 1'b0;
               zero_s  = 1'b0;
               state_s = IDLE;
               if (valid_in && final_in) begin
                  err_s  = 1'b1;
                  code_s = 2'b01;
               end else if (valid_in) begin
                  // Release cycle doubles as chunk 0 of the next frame
                  store_s = 1'b1;
                  cnt_s   = CW'(1);
                  or_s    = |data_in;
                  state_s = COLLECT;
               end else begin
                  cnt_s = '0;
               end
            end else if (valid_in) begin
               err_s   = 1'b1;
               code_s  = 2'b11;
               state_s = final_in ? HOLD : DROP;
            end else begin
               state_s = HOLD;
            end
         end
         DROP: begin
            if (valid_out && ready_in) begin
               valid_s = 1'b0;
               zero_s  = 1'b0;
            end else begin
               valid_s = valid_out;
            end
            if (valid_in && final_in) begin
               state_s = valid_s ? HOLD : IDLE;
            end else begin
               state_s = DROP;
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = '0;
         end
      endcase
   end

   // State register and registered outputs
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_r    <= IDLE;
         cnt_r      <= '0;
         or_r       <= 1'b0;
         data_out   <= '0;
         valid_out  <= 1'b0;
         zero_out   <= 1'b0;
         error_out  <= 1'b0;
         error_code <= 2'b00;
         busy_out   <= 1'b0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         or_r       <= or_s;
         valid_out  <= valid_s;
         zero_out   <= zero_s;
         error_out  <= err_s;
         error_code <= code_s;
         busy_out   <= (state_s == COLLECT) || (state_s == DROP);
         if (store_s) begin
            data_out[int'(cnt_r)*REGISTER_SIZE +: REGISTER_SIZE] <= data_in;
         end
      end
   end

endmodule

// File: tb/tb_great_deserializer.sv
// Randomized self-checking bench for great_deserializer with a queue-based
// frame model and a few hand-computed scenario checks.
module tb_great_deserializer;

   localparam int RS     = 32;
   localparam int BN     = 128;
   localparam int CHUNKS = BN / RS;

   logic          clk = 1'b0;
   logic          rst_in;
   logic [RS-1:0] data_in;
   logic          valid_in, final_in, ready_in;
   logic [BN-1:0] data_out;
   logic          valid_out, zero_out, error_out, busy_out;
   logic [1:0]    error_code;

   great_deserializer #(.REGISTER_SIZE(RS), .BITS_IN_NUM(BN)) dut (
      .clk_in(clk), .rst_in(rst_in), .data_in(data_in), .valid_in(valid_in),
      .final_in(final_in), .data_out(data_out), .valid_out(valid_out),
      .ready_in(ready_in), .zero_out(zero_out), .error_out(error_out),
      .error_code(error_code), .busy_out(busy_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Behavioural model: chunks of the frame under collection, held result
   logic [RS-1:0] m_q[$];
   logic          m_held = 1'b0;
   logic          m_drop = 1'b0;
   logic [BN-1:0] m_val  = '0;
   logic          m_zero = 1'b0;
   logic          m_err  = 1'b0;
   logic [1:0]    m_code = 2'b00;
   logic          cmp_en = 1'b1;

   task automatic check(input string name, input logic [BN-1:0] act, input logic [BN-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_held = 1'b0; m_drop = 1'b0; m_val = '0; m_zero = 1'b0;
      m_err = 1'b0; m_code = 2'b00;
   endtask

   task automatic flag(input logic [1:0] c);
      m_err = 1'b1;
      m_code = c;
   endtask

   task automatic model_update(input logic v, input logic f, input logic [RS-1:0] d, input logic r);
      logic [BN-1:0] p;
      m_err = 1'b0;
      if (m_drop) begin
         if (m_held && r) m_held = 1'b0;
         if (v && f) m_drop = 1'b0;
      end else if (m_held) begin
         if (r) begin
            m_held = 1'b0;
            if (v && f) flag(2'b01);
            else if (v) m_q.push_back(d);
         end else if (v) begin
            flag(2'b11);
            if (!f) m_drop = 1'b1;
         end
      end else if (v) begin
         if (m_q.size() < CHUNKS - 1) begin
            if (f) begin
               flag(2'b01);
               m_q.delete();
            end else begin
               m_q.push_back(d);
            end
         end else begin
            if (f) begin
               m_q.push_back(d);
               p = '0;
               for (int i = 0; i < CHUNKS; i++) p[i*RS +: RS] = m_q[i];
               m_val  = p;
               m_zero = (p == '0);
               m_held = 1'b1;
            end else begin
               flag(2'b10);
            end
            m_q.delete();
         end
      end
   endtask

   task automatic step(input logic v, input logic f, input logic [RS-1:0] d, input logic r);
      valid_in = v; final_in = f; data_in = d; ready_in = r;
      @(posedge clk);
      model_update(v, f, d, r);
      @(negedge clk);
   endtask

   // Cycle-by-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (cmp_en) begin
         check("valid_out", BN'(valid_out), BN'(m_held));
         check("error_out", BN'(error_out), BN'(m_err));
         check("error_code", BN'(error_code), BN'(m_code));
         check("busy_out", BN'(busy_out), BN'((m_q.size() > 0) || m_drop));
         if (m_held) begin
            check("data_out", data_out, m_val);
            check("zero_out", BN'(zero_out), BN'(m_zero));
         end
      end
   end

   logic [BN-1:0] frame_a;
   logic          zmode;
   logic          rv, rf, rr;
   logic [RS-1:0] rd;

   initial begin
      rst_in = 1'b0; valid_in = 1'b0; final_in = 1'b0; data_in = '0; ready_in = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_data", data_out, '0);
      check("rst_valid", BN'(valid_out), '0);
      check("rst_code", BN'(error_code), '0);
      rst_in = 1'b1;

      // Basic frame and all-zero frame
      step(1'b1, 1'b0, 32'h11111111, 1'b1);
      step(1'b1, 1'b0, 32'h22222222, 1'b1);
      step(1'b1, 1'b0, 32'h33333333, 1'b1);
      step(1'b1, 1'b1, 32'h44444444, 1'b1);
      check("basic_valid", BN'(valid_out), BN'(1'b1));
      check("basic_data", data_out, 128'h44444444_33333333_22222222_11111111);
      check("basic_zero", BN'(zero_out), '0);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      check("basic_release", BN'(valid_out), '0);
      for (int i = 0; i < CHUNKS; i++) step(1'b1, (i == CHUNKS - 1), 32'h0, 1'b0);
      check("zero_frame", BN'(zero_out), BN'(1'b1));
      step(1'b0, 1'b0, 32'h0, 1'b1);

      // Short frame then a good frame
      step(1'b1, 1'b0, 32'hAAAA0001, 1'b1);
      step(1'b1, 1'b1, 32'hAAAA0002, 1'b1);
      check("short_err", BN'(error_out), BN'(1'b1));
      check("short_code", BN'(error_code), BN'(2'b01));
      check("short_novalid", BN'(valid_out), '0);
      for (int i = 0; i < CHUNKS; i++) step(1'b1, (i == CHUNKS - 1), 32'hB0000000 + 32'(i), 1'b0);
      check("after_short", data_out, 128'hB0000003_B0000002_B0000001_B0000000);
      step(1'b0, 1'b0, 32'h0, 1'b1);

      // Missing final; fifth chunk starts a new frame
      for (int i = 0; i < CHUNKS; i++) step(1'b1, 1'b0, 32'hC0000000 + 32'(i), 1'b1);
      check("nofinal_code", BN'(error_code), BN'(2'b10));
      check("nofinal_busy", BN'(busy_out), '0);
      for (int i = 0; i < CHUNKS; i++) step(1'b1, (i == CHUNKS - 1), 32'hD0000000 + 32'(i), 1'b0);
      check("after_nofinal", data_out, 128'hD0000003_D0000002_D0000001_D0000000);

      // Overrun: frame A held while frame B streams in
      step(1'b0, 1'b0, 32'h0, 1'b1);
      frame_a = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
      for (int i = 0; i < CHUNKS; i++) step(1'b1, (i == CHUNKS - 1), frame_a[i*RS +: RS], 1'b0);
      for (int i = 0; i < CHUNKS; i++) begin
         step(1'b1, (i == CHUNKS - 1), 32'hE0000000 + 32'(i), 1'b0);
         if (i == 0) check("overrun_code", BN'(error_code), BN'(2'b11));
         check("overrun_keep", data_out, frame_a);
      end
      step(1'b0, 1'b0, 32'h0, 1'b1);
      check("overrun_release", BN'(valid_out), '0);

      // Back-to-back: B chunk 0 arrives in A's release cycle
      for (int i = 0; i < CHUNKS; i++) step(1'b1, (i == CHUNKS - 1), frame_a[i*RS +: RS], 1'b1);
      check("b2b_a", data_out, frame_a);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 32'hF0000000, 1'b1);
      check("b2b_released", BN'(valid_out), '0);
      for (int i = 1; i < CHUNKS; i++) step(1'b1, (i == CHUNKS - 1), 32'hF0000000 + 32'(i), 1'b0);
      check("b2b_b_valid", BN'(valid_out), BN'(1'b1));
      check("b2b_b_data", data_out, 128'hF0000003_F0000002_F0000001_F0000000);
      step(1'b0, 1'b0, 32'h0, 1'b1);

      // Asynchronous reset mid-frame
      step(1'b1, 1'b0, 32'h12345678, 1'b0);
      step(1'b1, 1'b0, 32'h9ABCDEF0, 1'b0);
      #2 rst_in = 1'b0;
      model_reset();
      #1;
      check("midrst_data", data_out, '0);
      check("midrst_busy", BN'(busy_out), '0);
      check("midrst_err", BN'(error_out), '0);
      @(negedge clk);
      rst_in = 1'b1;
      for (int i = 0; i < CHUNKS; i++) step(1'b1, (i == CHUNKS - 1), 32'h50000000 + 32'(i), 1'b0);
      check("postrst_data", data_out, 128'h50000003_50000002_50000001_50000000);
      check("postrst_code", BN'(error_code), '0);
      step(1'b0, 1'b0, 32'h0, 1'b1);

      // Randomized traffic against the model
      zmode = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) zmode = ~zmode;
         rv = ($urandom_range(0, 3) != 0);
         rf = ($urandom_range(0, 9) < 3);
         rr = ($urandom_range(0, 2) != 0);
         rd = zmode ? 32'h0 : 32'($urandom);
         step(rv, rf, rd, rr);
      end

      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
